rgb_pwm_fader: RTL and testbench

RGB_PWM_FADER -- requirements
Module: rgb_pwm_fader

---
 rtl/rgb_pkg.sv | 34 +++
 rtl/rgb_pwm_fader_if.sv | 12 +
 rtl/pwm_channel.sv | 18 +
 rtl/rgb_pwm_fader.sv | 114 +++++++++++
 tb/tb_rgb_pwm_fader.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rgb_pkg.sv
// Shared RGB definitions: color codes, duty width and the code-to-channel mask.
// Also used by the color sequencer.
package rgb_pkg;

  localparam int DUTY_W = 8;
  localparam logic [DUTY_W-1:0] DUTY_MAX = '1;

  localparam logic [2:0] CODE_RED     = 3'b000;
  localparam logic [2:0] CODE_YELLOW  = 3'b001;
  localparam logic [2:0] CODE_GREEN   = 3'b010;
  localparam logic [2:0] CODE_CYAN    = 3'b011;
  localparam logic [2:0] CODE_BLUE    = 3'b100;
  localparam logic [2:0] CODE_MAGENTA = 3'b101;
  localparam logic [2:0] CODE_OFF     = 3'b110;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FADE = 1'b1
  } fade_state_e;

  // Returns {R, G, B}; 1 means the channel is lit in that color.
  function automatic logic [2:0] color_mask(input logic [2:0] code);
    case (code)
      CODE_RED:     color_mask = 3'b100;
      CODE_YELLOW:  color_mask = 3'b110;
      CODE_GREEN:   color_mask = 3'b010;
      CODE_CYAN:    color_mask = 3'b011;
      CODE_BLUE:    color_mask = 3'b001;
      CODE_MAGENTA: color_mask = 3'b101;
      default:      color_mask = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/rgb_pwm_fader_if.sv
// Color request channel between a requester (master) and the fader (slave).
interface rgb_pwm_fader_if;
  // A request transfers on a rising clk edge where color_valid && color_ready;
  // color_code is only meaningful while color_valid is high. The fader does
  // not queue: a valid presented while color_ready is low is dropped.
  logic       color_valid;
  logic [2:0] color_code;
  logic       color_ready;

  modport master (output color_valid, output color_code, input color_ready);
  modport slave  (input color_valid, input color_code, output color_ready);
endinterface

// File: rtl/pwm_channel.sv
// One PWM output: compares a duty against the shared PWM counter and registers
// the drive. Full-scale duty is held solidly on.
module pwm_channel
  import rgb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DUTY_W-1:0] duty,
  input  logic [DUTY_W-1:0] pwm_cnt,
  output logic              drive
);

  always_ff @(posedge clk) begin
    if (rst) drive <= 1'b0;
    else     drive <= (duty == DUTY_MAX) || (pwm_cnt < duty);
  end

endmodule

// File: rtl/rgb_pwm_fader.sv
// RGB LED fader: accepts a color, ramps all three duties one count per fade
// tick toward the new targets, and drives three registered PWM outputs.
module rgb_pwm_fader
  import rgb_pkg::*;
#(
  parameter int PWM_DIV  = 1,
  parameter int FADE_DIV = 12000
) (
  input  logic             clk,
  input  logic             rst,
  rgb_pwm_fader_if.slave   req,
  output logic             busy,
  output logic             RGB_R,
  output logic             RGB_G,
  output logic             RGB_B,
  output fade_state_e      dbg_state
);

  localparam int PRE_W  = (PWM_DIV  > 1) ? $clog2(PWM_DIV)  : 1;
  localparam int FADE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PWM_DIV - 1);
  localparam logic [FADE_W-1:0] FADE_LAST = FADE_W'(FADE_DIV - 1);

  fade_state_e       state;
  logic              ready_q;
  logic [PRE_W-1:0]  pre_cnt;
  logic [DUTY_W-1:0] pwm_cnt;
  logic [FADE_W-1:0] fade_cnt;
  logic [DUTY_W-1:0] duty     [3];
  logic [DUTY_W-1:0] target   [3];
  logic [DUTY_W-1:0] duty_nxt [3];
  logic [DUTY_W-1:0] new_tgt  [3];
  logic [2:0]        mask;
  logic              differs;
  logic              all_done;

  assign req.color_ready = ready_q;
  assign dbg_state       = state;

  // Channel index 0/1/2 = R/G/B; mask bit 2-i belongs to channel i.
  always_comb begin
    mask     = color_mask(req.color_code);
    differs  = 1'b0;
    all_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      new_tgt[i]  = mask[2-i] ? DUTY_MAX : '0;
      duty_nxt[i] = duty[i];
      if (duty[i] < target[i])      duty_nxt[i] = duty[i] + 1'b1;
      else if (duty[i] > target[i]) duty_nxt[i] = duty[i] - 1'b1;
      if (new_tgt[i] != duty[i])    differs = 1'b1;
      if (duty_nxt[i] != target[i]) all_done = 1'b0;
    end
  end

  // Free-running PWM timebase; never disturbed by requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
      pwm_cnt <= pwm_cnt + 1'b1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ready_q  <= 1'b1;
      busy     <= 1'b0;
      fade_cnt <= '0;
      for (int i = 0; i < 3; i++) begin
        duty[i]   <= '0;
        target[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (req.color_valid && ready_q) begin
            for (int i = 0; i < 3; i++) target[i] <= new_tgt[i];
            fade_cnt <= '0;
            if (differs) begin
              state   <= ST_FADE;
              ready_q <= 1'b0;
              busy    <= 1'b1;
            end
          end
        end
        ST_FADE: begin
          // Counter wrap is the fade tick; leave as soon as the step lands.
          if (fade_cnt == FADE_LAST) begin
            fade_cnt <= '0;
            for (int i = 0; i < 3; i++) duty[i] <= duty_nxt[i];
            if (all_done) begin
              state   <= ST_IDLE;
              ready_q <= 1'b1;
              busy    <= 1'b0;
            end
          end else begin
            fade_cnt <= fade_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  pwm_channel u_ch_r (.clk(clk), .rst(rst), .duty(duty[0]), .pwm_cnt(pwm_cnt), .drive(RGB_R));
  pwm_channel u_ch_g (.clk(clk), .rst(rst), .duty(duty[1]), .pwm_cnt(pwm_cnt), .drive(RGB_G));
  pwm_channel u_ch_b (.clk(clk), .rst(rst), .duty(duty[2]), .pwm_cnt(pwm_cnt), .drive(RGB_B));

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Bench for rgb_pwm_fader: a time-based reference model predicts every cycle's
// {ready, busy, R, G, B}; a monitor compares them, plus directed fade checks.
module tb_rgb_pwm_fader;
  import rgb_pkg::*;

  localparam int PWM_DIV  = 1;
  localparam int FADE_DIV = 4;
  localparam int FULL_FADE = 255 * FADE_DIV;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        busy, rgb_r, rgb_g, rgb_b;
  fade_state_e dbg_state;
  rgb_pwm_fader_if fif ();

  rgb_pwm_fader #(.PWM_DIV(PWM_DIV), .FADE_DIV(FADE_DIV)) dut (
    .clk(clk), .rst(rst), .req(fif), .busy(busy),
    .RGB_R(rgb_r), .RGB_G(rgb_g), .RGB_B(rgb_b), .dbg_state(dbg_state)
  );

  int tests = 0;
  int fails = 0;
  logic [4:0] exp_q[$];

  // ---------------- reference model ----------------
  // The light is described by the last acceptance: the cycle it happened, the
  // duties at that moment and the targets. Duty at any later cycle follows from
  // elapsed time: one step per FADE_DIV cycles, capped at the target.
  int cyc = 0;
  int t_acc = 0;
  int pwm0 = 0;
  int m_start[3];
  int m_tgt[3];

  function automatic logic [2:0] ref_mask(input logic [2:0] code);
    case (code)
      3'd0: return 3'b100;
      3'd1: return 3'b110;
      3'd2: return 3'b010;
      3'd3: return 3'b011;
      3'd4: return 3'b001;
      3'd5: return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  function automatic int duty_at(input int ch, input int n);
    int k, d;
    k = (n - t_acc) / FADE_DIV;
    d = m_tgt[ch] - m_start[ch];
    if (d >= 0) return m_start[ch] + ((k < d) ? k : d);
    else        return m_start[ch] - ((k < -d) ? k : -d);
  endfunction

  function automatic bit busy_at(input int n);
    int md, d;
    md = 0;
    for (int ch = 0; ch < 3; ch++) begin
      d = m_tgt[ch] - m_start[ch];
      if (d < 0) d = -d;
      if (d > md) md = d;
    end
    return (n - t_acc) < md * FADE_DIV;
  endfunction

  function automatic int pwm_at(input int n);
    return ((n - pwm0) / PWM_DIV) % 256;
  endfunction

  always @(posedge clk) begin
    logic [2:0] o;
    logic [2:0] m;
    int n, d;
    bit b;
    cyc++;
    n = cyc;
    // Outputs after this edge reflect the duty and counter held before it.
    for (int ch = 0; ch < 3; ch++) begin
      d = duty_at(ch, n - 1);
      o[2-ch] = (d == 255) || (pwm_at(n - 1) < d);
    end
    if (rst) begin
      o = 3'b000;
      t_acc = n;
      pwm0 = n;
      for (int ch = 0; ch < 3; ch++) begin
        m_start[ch] = 0;
        m_tgt[ch] = 0;
      end
    end else if (fif.color_valid && !busy_at(n - 1)) begin
      m = ref_mask(fif.color_code);
      for (int ch = 0; ch < 3; ch++) begin
        m_start[ch] = duty_at(ch, n - 1);
        m_tgt[ch] = m[2-ch] ? 255 : 0;
      end
      t_acc = n;
    end
    b = busy_at(n);
    exp_q.push_back({!b, b, o});
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [4:0] e;
    logic [5:0] act;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {dbg_state == ST_FADE, fif.color_ready, busy, rgb_r, rgb_g, rgb_b};
      tests++;
      if (act !== {e[3], e}) begin
        fails++;
        $display("FAIL rgb_cycle %0d: got fade/rdy/busy/rgb=%b expected %b", cyc, act, {e[3], e});
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [2:0] c);
    @(negedge clk);
    fif.color_valid = 1'b1;
    fif.color_code = c;
    @(negedge clk);
    fif.color_valid = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at the negedge right after acceptance; counts busy cycles.
  task automatic measure(output int dur);
    dur = 0;
    while (busy === 1'b1 && dur < 3000) begin
      dur++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      n++;
      @(negedge clk);
    end
    tests++;
    if (n >= 3000) begin
      fails++;
      $display("FAIL idle_timeout: busy still %b after %0d cycles", busy, n);
    end
  endtask

  task automatic count_busy(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (busy !== 1'b0) c++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dur, c, gap;
    logic [2:0] code;
    fif.color_valid = 1'b0;
    fif.color_code = 3'b000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(5);

    send(CODE_RED);
    measure(dur);
    check("red_fade_len", dur, FULL_FADE);
    idle(300);

    send(CODE_CYAN);
    measure(dur);
    check("cyan_fade_len", dur, FULL_FADE);
    idle(300);

    // A request arriving mid-fade is dropped; the fade must end at BLUE once.
    send(CODE_BLUE);
    idle(200);
    @(negedge clk);
    fif.color_valid = 1'b1;
    fif.color_code = CODE_GREEN;
    @(negedge clk);
    fif.color_valid = 1'b0;
    wait_idle();
    count_busy(300, c);
    check("ignored_no_refade", c, 0);

    send(CODE_YELLOW);
    measure(dur);
    check("yellow_fade_len", dur, FULL_FADE);
    idle(300);
    send(3'b111);
    measure(dur);
    check("off_fade_len", dur, FULL_FADE);
    idle(300);

    // Reset around step 100, then a fresh RED must start from zero duty.
    send(CODE_RED);
    idle(400);
    pulse_rst();
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(fif.color_ready), 1);
    check("rst_rgb", int'({rgb_r, rgb_g, rgb_b}), 0);
    idle(20);
    send(CODE_RED);
    measure(dur);
    check("red_after_rst_len", dur, FULL_FADE);
    idle(300);

    send(CODE_RED);
    count_busy(300, c);
    check("resend_busy", c, 0);
    check("resend_ready", int'(fif.color_ready), 1);

    for (int it = 0; it < 10; it++) begin
      code = 3'($urandom_range(0, 7));
      wait_idle();
      send(code);
      gap = $urandom_range(0, 1100);
      for (int i = 0; i < gap; i++) begin
        @(negedge clk);
        if ($urandom_range(0, 49) == 0) begin
          fif.color_valid = 1'b1;
          fif.color_code = 3'($urandom_range(0, 7));
          @(negedge clk);
          fif.color_valid = 1'b0;
        end
      end
      if ($urandom_range(0, 3) == 0) pulse_rst();
      wait_idle();
      idle(300);
    end

    idle(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
